// File: rtl/ncl_pkg.sv
// ncl_pkg: shared NCL dual-rail types, rail codes, handshake states and wavefront classification
package ncl_pkg;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  localparam dual_rail_logic DR_NULL    = 2'b00;
  localparam dual_rail_logic DR_ZERO    = 2'b01;
  localparam dual_rail_logic DR_ONE     = 2'b10;
  localparam dual_rail_logic DR_ILLEGAL = 2'b11;

  typedef enum logic {
    REQ_NULL,
    REQ_DATA
  } state_e;

  typedef enum logic [1:0] {
    CLS_TRANSITION,
    CLS_DATA,
    CLS_NULL,
    CLS_ILLEGAL
  } dr_class_e;

  localparam int MAX_PAIRS = 32;

  // Classifies the low 'pairs' rail pairs; an illegal pair dominates every other outcome
  function automatic dr_class_e dr_class(input logic [2*MAX_PAIRS-1:0] rails, input int pairs);
    logic any_ill;
    logic all_null;
    logic all_data;
    dual_rail_logic p;
    any_ill  = 1'b0;
    all_null = 1'b1;
    all_data = 1'b1;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      if (i < pairs) begin
        p        = rails[2*i +: 2];
        any_ill  = any_ill | (p == DR_ILLEGAL);
        all_null = all_null & (p == DR_NULL);
        all_data = all_data & ((p == DR_ZERO) | (p == DR_ONE));
      end
    end
    return any_ill ? CLS_ILLEGAL : all_null ? CLS_NULL : all_data ? CLS_DATA : CLS_TRANSITION;
  endfunction

endpackage

// File: rtl/ncl_prod_capture_if.sv
// ncl_prod_capture_if: dual-rail product / ki handshake plus the clocked valid/ready product stream
interface ncl_prod_capture_if
  import ncl_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
);
  dual_rail_logic [WIDTH-1:0] po;
  logic ki;
  logic [WIDTH-1:0] prod_data;
  logic prod_valid;
  logic prod_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic err_illegal;

  modport master (
    output po, prod_ready,
    input  ki, prod_data, prod_valid, fifo_count, err_illegal
  );

  modport slave (
    input  po, prod_ready,
    output ki, prod_data, prod_valid, fifo_count, err_illegal
  );
endinterface

// File: rtl/ncl_sync_fifo.sv
// ncl_sync_fifo: show-ahead synchronous FIFO with occupancy count, reusable on both sides of the multiplier
module ncl_sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop_req,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;

  assign valid = count != '0;
  assign full  = count == (AW+1)'(DEPTH);
  assign rd    = pop_req && valid;
  assign wr    = push && (!full || rd);
  assign head  = valid ? mem[rp] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= push_data;
  end
endmodule

// File: rtl/ncl_prod_capture.sv
// ncl_prod_capture: clocked NCL product receiver driving ki and queueing decoded wavefronts
module ncl_prod_capture
  import ncl_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  ncl_prod_capture_if.slave bus
);
  logic [SYNC_STAGES-1:0][2*WIDTH-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic [2*WIDTH-1:0] s;
  dr_class_e cls, cls_q;
  state_e state, state_n;
  logic stable, full, ki, push, err;
  logic [WIDTH-1:0] dec;

  assign s      = sync[SYNC_STAGES-1];
  assign cls    = fill[SYNC_STAGES-1] ? dr_class((2*MAX_PAIRS)'(s), WIDTH) : CLS_TRANSITION;
  assign stable = cls == cls_q;

  assign bus.ki          = ki;
  assign bus.err_illegal = err;

  // Rail synchronizers; 'fill' keeps the cleared stages from posing as a real NULL wavefront
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      fill <= '0;
    end else begin
      sync[0] <= bus.po;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Previous-cycle class, so a class only acts once it has held for two cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cls_q <= CLS_TRANSITION;
    else     cls_q <= cls;
  end

  // Sticky illegal-rail flag; the handshake keeps running regardless
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err <= 1'b0;
    else if (stable && cls == CLS_ILLEGAL) err <= 1'b1;
  end

  // Handshake state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ_NULL;
    else     state <= state_n;
  end

  // Request DATA only with room reserved in the FIFO; return to NULL on the push edge
  always_comb begin
    state_n = (state == REQ_NULL)
            ? ((stable && cls == CLS_NULL && !full) ? REQ_DATA : REQ_NULL)
            : ((stable && cls == CLS_DATA) ? REQ_NULL : REQ_DATA);
  end

  // ki, push strobe and rail1 decode of the synchronized wavefront
  always_comb begin
    ki   = state == REQ_DATA;
    push = ki && stable && cls == CLS_DATA;
    dec  = '0;
    for (int i = 0; i < WIDTH; i++) dec[i] = s[2*i+1];
  end

  ncl_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(dec),
    .pop_req  (bus.prod_ready),
    .head     (bus.prod_data),
    .valid    (bus.prod_valid),
    .full     (full),
    .count    (bus.fifo_count)
  );
endmodule

// File: tb/tb_ncl_prod_capture.sv
// tb_ncl_prod_capture: directed NCL handshake stimulus with a scoreboard of decoded products
module tb_ncl_prod_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;
  logic [11:0] raw;

  ncl_prod_capture_if #(.WIDTH(6), .DEPTH(4)) bus ();

  ncl_prod_capture #(.WIDTH(6), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] enc(input logic [5:0] v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ki(input logic v, input int budget);
    int n;
    n = 0;
    while (bus.ki !== v && n < budget) begin
      tick(1);
      n++;
    end
    chk("ki_wait", bus.ki, v);
  endtask

  task automatic wavefront(input logic [5:0] v);
    wait_ki(1'b1, 10);
    bus.po = enc(v);
    exp_q.push_back(v);
    wait_ki(1'b0, 10);
    bus.po = '0;
  endtask

  // Every pop is scored against the oldest outstanding product
  always @(negedge clk) begin
    if (!rst && bus.prod_valid && bus.prod_ready) begin
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'bx;
      chk("pop_data", bus.prod_data, mon_exp);
    end
  end

  initial begin
    bus.po = '0;
    bus.prod_ready = 1'b0;
    #12;
    chk("rst_ki", bus.ki, 0);
    chk("rst_valid", bus.prod_valid, 0);
    chk("rst_data", bus.prod_data, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_err", bus.err_illegal, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      tick(1);
      chk("ki_startup_low", bus.ki, 0);
    end
    tick(1);
    chk("ki_startup_rise", bus.ki, 1);
    chk("startup_valid", bus.prod_valid, 0);

    bus.prod_ready = 1'b1;
    bus.po = enc(6'd14);
    exp_q.push_back(6'd14);
    tick(3);
    chk("lat_ki_hold", bus.ki, 1);
    chk("lat_no_valid", bus.prod_valid, 0);
    tick(1);
    chk("push_ki_fall", bus.ki, 0);
    chk("push_valid", bus.prod_valid, 1);
    chk("push_data14", bus.prod_data, 14);
    chk("push_count", bus.fifo_count, 1);
    tick(1);
    chk("popped_valid", bus.prod_valid, 0);
    chk("popped_count", bus.fifo_count, 0);
    bus.po = '0;
    wait_ki(1'b1, 8);

    bus.prod_ready = 1'b0;
    wavefront(6'd15);
    wavefront(6'd49);
    wait_ki(1'b1, 10);
    chk("two_count", bus.fifo_count, 2);
    chk("two_head", bus.prod_data, 15);
    bus.prod_ready = 1'b1;
    tick(3);
    bus.prod_ready = 1'b0;
    chk("two_drained", bus.fifo_count, 0);

    wavefront(6'd33);
    wavefront(6'd42);
    wavefront(6'd7);
    wavefront(6'd63);
    tick(8);
    chk("full_ki_low", bus.ki, 0);
    chk("full_count", bus.fifo_count, 4);
    bus.prod_ready = 1'b1;
    tick(1);
    bus.prod_ready = 1'b0;
    chk("after_pop_count", bus.fifo_count, 3);
    chk("after_pop_ki_low", bus.ki, 0);
    tick(1);
    chk("after_pop_ki_rise", bus.ki, 1);
    bus.po = enc(6'd0);
    exp_q.push_back(6'd0);
    wait_ki(1'b0, 10);
    bus.po = '0;
    chk("fifth_count", bus.fifo_count, 4);
    chk("err_clean", bus.err_illegal, 0);
    bus.prod_ready = 1'b1;
    tick(6);
    bus.prod_ready = 1'b0;
    chk("full_drained", bus.fifo_count, 0);

    wait_ki(1'b1, 10);
    raw = enc(6'd0);
    raw[7:6] = 2'b11;
    bus.po = raw;
    tick(4);
    chk("ill_err", bus.err_illegal, 1);
    chk("ill_ki_hold", bus.ki, 1);
    chk("ill_no_push", bus.fifo_count, 0);
    bus.po = enc(6'd16);
    exp_q.push_back(6'd16);
    wait_ki(1'b0, 10);
    bus.po = '0;
    chk("ill_err_sticky", bus.err_illegal, 1);
    chk("ill_push_count", bus.fifo_count, 1);
    chk("ill_push_data", bus.prod_data, 16);

    wavefront(6'd9);
    wait_ki(1'b1, 10);
    chk("pre_rst_count", bus.fifo_count, 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ki", bus.ki, 0);
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_valid", bus.prod_valid, 0);
    chk("arst_err", bus.err_illegal, 0);
    exp_q.delete();
    bus.po = '0;
    tick(2);
    rst = 1'b0;
    wait_ki(1'b1, 10);
    bus.prod_ready = 1'b1;
    wavefront(6'd21);
    tick(6);
    chk("queue_drained", exp_q.size(), 0);
    chk("end_count", bus.fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
